// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM encodings
// and the alignment rule used by both the store path and the trap logic.
package mem_stage_pkg;

    typedef logic [1:0] size_t;

    // Access size codes; 2'b10 is decoded as a word access.
    localparam size_t SZ_BYTE = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_WORD = 2'b11;

    // Stage FSM encodings.
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Byte accesses are always aligned; halves need an even address, words a
    // multiple of four.
    function automatic logic is_aligned(input size_t size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            default: ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM -> MEM/WB bus plus the debug-unit read port.
interface mem_stage_if #(
    parameter int unsigned ADDR_W = 8
);
    // Inputs from EX/MEM and the debug unit
    logic [31:0]       i_m_alu_result;
    logic [31:0]       i_m_write_data;
    logic [4:0]        i_m_rd;
    logic              i_m_mem_read;
    logic              i_m_mem_write;
    logic              i_m_mem_to_reg;
    logic              i_m_reg_write;
    logic [1:0]        i_m_size;
    logic              i_m_unsigned;
    logic              i_du_rd_en;
    logic [ADDR_W-1:0] i_du_addr;

    // Outputs towards MEM/WB, the hazard unit and the debug unit
    logic [31:0]       o_m_read_data;
    logic [31:0]       o_m_alu_result;
    logic [4:0]        o_m_rd;
    logic              o_m_mem_to_reg;
    logic              o_m_reg_write;
    logic              o_busy;
    logic              o_misaligned;
    logic [31:0]       o_misaligned_addr;
    logic [31:0]       o_du_data;
    logic              o_du_valid;

    modport master (
        output i_m_alu_result, i_m_write_data, i_m_rd, i_m_mem_read, i_m_mem_write,
               i_m_mem_to_reg, i_m_reg_write, i_m_size, i_m_unsigned, i_du_rd_en, i_du_addr,
        input  o_m_read_data, o_m_alu_result, o_m_rd, o_m_mem_to_reg, o_m_reg_write,
               o_busy, o_misaligned, o_misaligned_addr, o_du_data, o_du_valid
    );

    modport slave (
        input  i_m_alu_result, i_m_write_data, i_m_rd, i_m_mem_read, i_m_mem_write,
               i_m_mem_to_reg, i_m_reg_write, i_m_size, i_m_unsigned, i_du_rd_en, i_du_addr,
        output o_m_read_data, o_m_alu_result, o_m_rd, o_m_mem_to_reg, o_m_reg_write,
               o_busy, o_misaligned, o_misaligned_addr, o_du_data, o_du_valid
    );

endinterface

// File: rtl/mem_stage_load_formatter.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module mem_stage_load_formatter
    import mem_stage_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  size_t       size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select (little-endian) followed by extension.
    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            SZ_BYTE: data_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte-lane data memory with a post-reset clear sweep,
// sticky misalignment trap and a one-cycle-latency debug read port.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input logic        i_clk,
    input logic        i_reset,
    mem_stage_if.slave bus_io
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              mis_q, mis_d;
    logic [31:0]       mis_addr_q, mis_addr_d;
    logic [31:0]       du_data_q;
    logic              du_valid_q;

    logic              run;
    logic              access;
    logic              aligned;
    logic              trap;
    logic              store_en;
    logic [ADDR_W-1:0] widx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_lanes;
    logic [31:0]       fmt_data;

    // Access decode: upper address bits beyond the memory wrap silently.
    always_comb begin
        run      = (state_q == ST_RUN);
        access   = bus_io.i_m_mem_read | bus_io.i_m_mem_write;
        aligned  = is_aligned(bus_io.i_m_size, bus_io.i_m_alu_result[1:0]);
        trap     = run & access & ~aligned;
        store_en = run & bus_io.i_m_mem_write & aligned;
        widx     = bus_io.i_m_alu_result[ADDR_W+1:2];

        case (bus_io.i_m_size)
            SZ_BYTE: begin
                wr_be    = 4'b0001 << bus_io.i_m_alu_result[1:0];
                wr_lanes = {4{bus_io.i_m_write_data[7:0]}};
            end
            SZ_HALF: begin
                wr_be    = bus_io.i_m_alu_result[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{bus_io.i_m_write_data[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = bus_io.i_m_write_data;
            end
        endcase
    end

    // Next state: sweep the memory once after reset, then run until reset.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mis_d      = mis_q | trap;
        mis_addr_d = mis_addr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == {ADDR_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
        // Only the first offending address is kept.
        if (trap && !mis_q) begin
            mis_addr_d = bus_io.i_m_alu_result;
        end
    end

    // Control, trap and debug registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            du_data_q  <= '0;
            du_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            du_valid_q <= bus_io.i_du_rd_en;
            // Reads the array before this edge's store lands: pre-store data.
            if (bus_io.i_du_rd_en) begin
                du_data_q <= mem_q[bus_io.i_du_addr];
            end
        end
    end

    // Memory array: clear sweep in INIT, byte-lane stores in RUN.
    always_ff @(posedge i_clk) begin
        if (!run) begin
            mem_q[ptr_q] <= '0;
        end else if (store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) begin
                    mem_q[widx][8*l +: 8] <= wr_lanes[8*l +: 8];
                end
            end
        end
    end

    mem_stage_load_formatter u_load_formatter (
        .word_i     (mem_q[widx]),
        .addr_i     (bus_io.i_m_alu_result[1:0]),
        .size_i     (bus_io.i_m_size),
        .unsigned_i (bus_io.i_m_unsigned),
        .data_o     (fmt_data)
    );

    // Outputs: loads read as zero while clearing or when trapped.
    always_comb begin
        bus_io.o_m_read_data     = (run && !trap) ? fmt_data : 32'd0;
        bus_io.o_m_alu_result    = bus_io.i_m_alu_result;
        bus_io.o_m_rd            = bus_io.i_m_rd;
        bus_io.o_m_mem_to_reg    = bus_io.i_m_mem_to_reg;
        bus_io.o_m_reg_write     = bus_io.i_m_reg_write & ~trap;
        bus_io.o_busy            = ~run;
        bus_io.o_misaligned      = mis_q;
        bus_io.o_misaligned_addr = mis_addr_q;
        bus_io.o_du_data         = du_data_q;
        bus_io.o_du_valid        = du_valid_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected load/debug
// responses, a negedge monitor pops and compares them.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        rw;
        logic [31:0] alu;
        logic [4:0]  rd;
    } ld_exp_t;

    typedef struct {
        string       name;
        logic [31:0] data;
    } du_exp_t;

    logic    clk = 1'b0;
    logic    rst;
    int      n_cmp  = 0;
    int      n_fail = 0;
    ld_exp_t ld_q[$];
    du_exp_t du_q[$];
    ld_exp_t mon_ld;
    du_exp_t mon_du;
    logic [4:0] rd_tag = 5'd1;

    mem_stage_if #(.ADDR_W(ADDR_W)) bus ();

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_m_alu_result = '0;
        bus.i_m_write_data = '0;
        bus.i_m_rd         = '0;
        bus.i_m_mem_read   = 1'b0;
        bus.i_m_mem_write  = 1'b0;
        bus.i_m_mem_to_reg = 1'b0;
        bus.i_m_reg_write  = 1'b0;
        bus.i_m_size       = SZ_WORD;
        bus.i_m_unsigned   = 1'b0;
        bus.i_du_rd_en     = 1'b0;
        bus.i_du_addr      = '0;
    endtask

    task automatic load(input string name, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] exp, input logic exp_rw);
        ld_exp_t e;
        e.name = name;
        e.data = exp;
        e.rw   = exp_rw;
        e.alu  = addr;
        e.rd   = rd_tag;
        ld_q.push_back(e);
        bus.i_m_alu_result = addr;
        bus.i_m_rd         = rd_tag;
        bus.i_m_mem_read   = 1'b1;
        bus.i_m_mem_to_reg = 1'b1;
        bus.i_m_reg_write  = 1'b1;
        bus.i_m_size       = size;
        bus.i_m_unsigned   = uns;
        rd_tag             = rd_tag + 5'd1;
        cycle();
        idle_inputs();
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size);
        bus.i_m_alu_result = addr;
        bus.i_m_write_data = wdata;
        bus.i_m_mem_write  = 1'b1;
        bus.i_m_size       = size;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size);
        set_store(addr, wdata, size);
        cycle();
        idle_inputs();
    endtask

    task automatic set_du(input string name, input logic [ADDR_W-1:0] waddr,
                          input logic [31:0] exp);
        du_exp_t e;
        e.name = name;
        e.data = exp;
        du_q.push_back(e);
        bus.i_du_rd_en = 1'b1;
        bus.i_du_addr  = waddr;
    endtask

    task automatic du_read(input string name, input logic [ADDR_W-1:0] waddr,
                           input logic [31:0] exp);
        set_du(name, waddr, exp);
        cycle();
        idle_inputs();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, bus.o_busy, 1);
        check({tag, "_mis"}, bus.o_misaligned, 0);
        check({tag, "_mis_addr"}, bus.o_misaligned_addr, 0);
        check({tag, "_du_data"}, bus.o_du_data, 0);
        check({tag, "_du_valid"}, bus.o_du_valid, 0);
    endtask

    // Reset is released just after a posedge; counts edges spent busy.
    task automatic count_busy(input string tag);
        int n = 0;
        while (bus.o_busy && n < 2 * DEPTH) begin
            cycle();
            n++;
        end
        check({tag, "_busy_cycles"}, n, DEPTH);
    endtask

    // Monitor: compares every presented load result and debug response.
    always @(negedge clk) begin
        if (bus.i_m_mem_read) begin
            if (ld_q.size() == 0) begin
                check("ld_unexpected", 1, 0);
            end else begin
                mon_ld = ld_q.pop_front();
                check({mon_ld.name, "_data"}, bus.o_m_read_data, mon_ld.data);
                check({mon_ld.name, "_regwr"}, bus.o_m_reg_write, mon_ld.rw);
                check({mon_ld.name, "_alu"}, bus.o_m_alu_result, mon_ld.alu);
                check({mon_ld.name, "_rd"}, bus.o_m_rd, mon_ld.rd);
                check({mon_ld.name, "_m2r"}, bus.o_m_mem_to_reg, 1);
            end
        end
        if (bus.o_du_valid) begin
            if (du_q.size() == 0) begin
                check("du_unexpected_valid", 1, 0);
            end else begin
                mon_du = du_q.pop_front();
                check(mon_du.name, bus.o_du_data, mon_du.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) cycle();
        check_reset_vals("rst0");
        rst = 1'b0;
        count_busy("sweep0");

        // Cleared memory
        load("lw_clr_44", 32'h0000_0044, SZ_WORD, 1'b0, 32'h0, 1'b1);
        load("lw_clr_3fc", 32'h0000_03FC, SZ_WORD, 1'b0, 32'h0, 1'b1);

        // Sub-word loads of 0x8000_00F0
        store(32'h0000_0010, 32'h8000_00F0, SZ_WORD);
        load("lb_10", 32'h0000_0010, SZ_BYTE, 1'b0, 32'hFFFF_FFF0, 1'b1);
        load("lbu_13", 32'h0000_0013, SZ_BYTE, 1'b1, 32'h0000_0080, 1'b1);
        load("lh_12", 32'h0000_0012, SZ_HALF, 1'b0, 32'hFFFF_8000, 1'b1);
        load("lhu_12", 32'h0000_0012, SZ_HALF, 1'b1, 32'h0000_8000, 1'b1);
        load("lh_10", 32'h0000_0010, SZ_HALF, 1'b0, 32'h0000_00F0, 1'b1);
        load("lw_10", 32'h0000_0010, SZ_WORD, 1'b0, 32'h8000_00F0, 1'b1);

        // Byte and half stores only touch their lanes
        store(32'h0000_0021, 32'hDEAD_BEAB, SZ_BYTE);
        load("lw_20_sb", 32'h0000_0020, SZ_WORD, 1'b0, 32'h0000_AB00, 1'b1);
        store(32'h0000_0022, 32'hFFFF_1234, SZ_HALF);
        load("lw_20_sh", 32'h0000_0020, SZ_WORD, 1'b0, 32'h1234_AB00, 1'b1);

        // Upper address bits wrap onto word 16
        store(32'h0000_0440, 32'hA5A5_0F0F, 2'b10);
        load("lw_40_wrap", 32'h0000_0040, SZ_WORD, 1'b0, 32'hA5A5_0F0F, 1'b1);

        // Misalignment trap
        store(32'h0000_0030, 32'h1122_3344, SZ_WORD);
        load("lw_06_mis", 32'h0000_0006, SZ_WORD, 1'b0, 32'h0, 1'b0);
        check("mis_flag", bus.o_misaligned, 1);
        check("mis_addr", bus.o_misaligned_addr, 32'h0000_0006);
        store(32'h0000_0031, 32'h0000_BEEF, SZ_HALF);
        check("mis_flag_kept", bus.o_misaligned, 1);
        check("mis_addr_kept", bus.o_misaligned_addr, 32'h0000_0006);
        load("lw_30_unchanged", 32'h0000_0030, SZ_WORD, 1'b0, 32'h1122_3344, 1'b1);

        // Debug read concurrent with a store to the same word
        set_store(32'h0000_0010, 32'h0000_0055, SZ_WORD);
        set_du("du_w4_prestore", 8'd4, 32'h8000_00F0);
        cycle();
        idle_inputs();
        du_read("du_w4_poststore", 8'd4, 32'h0000_0055);
        cycle();
        check("du_valid_pulse_end", bus.o_du_valid, 0);
        load("lw_10_new", 32'h0000_0010, SZ_WORD, 1'b0, 32'h0000_0055, 1'b1);
        store(32'h0000_0080, 32'hCAFE_0001, SZ_WORD);

        // Reset in the middle of a store
        set_store(32'h0000_0010, 32'h0000_0077, SZ_WORD);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_store");
        idle_inputs();
        cycle();
        cycle();
        rst = 1'b0;

        // Mid-sweep: word 32 not yet cleared, loads return zero
        cycle();
        cycle();
        du_read("du_w32_init", 8'd32, 32'hCAFE_0001);
        load("lw_init", 32'h0000_0080, SZ_WORD, 1'b0, 32'h0, 1'b1);
        check("init_busy", bus.o_busy, 1);

        // Reset mid-sweep restarts the full sweep
        rst = 1'b1;
        #1;
        check_reset_vals("rst_sweep");
        cycle();
        cycle();
        rst = 1'b0;
        count_busy("sweep1");
        load("lw_10_cleared", 32'h0000_0010, SZ_WORD, 1'b0, 32'h0, 1'b1);
        du_read("du_w32_cleared", 8'd32, 32'h0);
        cycle();
        check("mis_after_reset", bus.o_misaligned, 0);

        check("ld_q_drained", ld_q.size(), 0);
        check("du_q_drained", du_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
